// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: constants shared by the instruction-fetch front end
package fetch_unit_pkg;
  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam logic [31:0] NOP_INSTR = 32'b0;
  localparam int PC_STEP = 4;
endpackage

// File: rtl/fetch_unit_fifo.sv
// fetch_fifo: in-order fetch queue of {instruction, pc+4} with flush and occupancy count
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 64,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count
);
  logic [W-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  // pointers wrap naturally since DEPTH is a power of two; flush empties outright
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  // storage needs no reset: only slots below count are ever presented
  always_ff @(posedge clock)
    if (push && !flush) mem[wr_ptr] <= din;
  assign dout = mem[rd_ptr];
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner, imem request issue, in-flight tracking and decode hand-off
module fetch_unit import fetch_unit_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              stall,
  output logic              id_valid,
  output logic [DATA_W-1:0] id_instr,
  output logic [ADDR_W-1:0] id_pc_next
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);
  logic [ADDR_W-1:0] pc, resp_pc, redirect_tgt, head_pc_next;
  logic [DATA_W-1:0] head_instr;
  logic [CW-1:0] count, live, discard, live_n, discard_n;
  logic [CW:0] used_q, used_m;
  logic run, issue, rv_push, pop;
  assign redirect_tgt = redirect_pc & ~ADDR_W'(3);
  assign used_q = {1'b0, count} + {1'b0, live};
  assign used_m = {1'b0, live} + {1'b0, discard};
  assign imem_req = run & !redirect_valid & (used_q < (CW+1)'(FIFO_DEPTH)) & (used_m < (CW+1)'(FIFO_DEPTH));
  assign imem_addr = pc;
  assign issue = imem_req & imem_gnt;
  assign rv_push = imem_rvalid & !redirect_valid & (discard == '0) & (live != '0);
  assign id_valid = (count != '0) & !redirect_valid;
  assign pop = id_valid & !stall;
  assign id_instr = id_valid ? head_instr : DATA_W'(NOP_INSTR);
  assign id_pc_next = id_valid ? head_pc_next : '0;
  // a redirect folds everything still in flight into the discard count, including any
  // response landing in the same cycle
  always_comb begin
    live_n = redirect_valid ? '0 : live + CW'(issue) - CW'(rv_push);
    discard_n = (redirect_valid ? discard + live : discard)
              - CW'(imem_rvalid & ((discard != '0) | (redirect_valid & (live != '0))));
  end
  // resp_pc is the address of the next kept response, so each pushed word carries its own pc+4
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      run <= 1'b0;
      pc <= RESET_PC;
      resp_pc <= RESET_PC;
      live <= '0;
      discard <= '0;
    end else begin
      run <= 1'b1;
      pc <= redirect_valid ? redirect_tgt : issue ? pc + STEP : pc;
      resp_pc <= redirect_valid ? redirect_tgt : rv_push ? resp_pc + STEP : resp_pc;
      live <= live_n;
      discard <= discard_n;
    end
  fetch_fifo #(.DEPTH(FIFO_DEPTH), .W(DATA_W + ADDR_W)) u_fifo (
    .clock(clock),
    .reset(reset),
    .flush(redirect_valid),
    .push(rv_push),
    .pop(pop),
    .din({imem_rdata, resp_pc + STEP}),
    .dout({head_instr, head_pc_next}),
    .count(count)
  );
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vectors, corner sequences and randomized checks against a stream model
module tb_fetch_unit;
  import fetch_unit_pkg::*;
  localparam int DEPTH = 4;
  localparam logic O = 1'b1;
  localparam logic Z = 1'b0;
  logic clock = 1'b0, reset = 1'b1;
  logic imem_req, imem_gnt, imem_rvalid, redirect_valid, stall, id_valid;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, id_instr, id_pc_next;
  logic w_req, w_gnt, w_rvalid, w_idv;
  logic [31:0] w_addr, w_rdata, w_ins, w_pcn;
  int n_chk = 0, n_fail = 0;
  typedef struct { logic [31:0] addr; int due; } pend_t;
  pend_t pend[$];
  logic [31:0] exp_pc, exp_dpc;
  int cyc = 0, lat_min = 1, lat_max = 1, pops = 0, issues = 0;
  logic last_req, last_idv;
  logic [31:0] last_ins, last_pcn;
  typedef struct {
    logic g, rv; logic [31:0] rd; logic st, rdv; logic [31:0] rpc;
    logic req; logic [31:0] addr; logic idv; logic [31:0] ins, pcn;
  } vec_t;

  always #5 clock = ~clock;

  fetch_unit #(.ADDR_W(32), .DATA_W(32), .RESET_PC(32'h0), .FIFO_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall(stall),
    .id_valid(id_valid), .id_instr(id_instr), .id_pc_next(id_pc_next));

  fetch_unit #(.ADDR_W(32), .DATA_W(32), .RESET_PC(32'hFFFF_FFFC), .FIFO_DEPTH(DEPTH)) u_wrap (
    .clock(clock), .reset(reset), .imem_req(w_req), .imem_addr(w_addr),
    .imem_gnt(w_gnt), .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
    .redirect_valid(1'b0), .redirect_pc(32'h0), .stall(1'b0),
    .id_valid(w_idv), .id_instr(w_ins), .id_pc_next(w_pcn));

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic chk_b(input string nm, input logic act, input logic req);
    chk(nm, {31'b0, act}, {31'b0, req});
  endtask

  // one clock of the memory/decode environment, scored against the fetch-stream model
  task automatic step(input logic s, input logic rd, input logic [31:0] rt, input logic g);
    logic resp, iss, popd;
    @(negedge clock);
    stall = s;
    redirect_valid = rd;
    redirect_pc = rt;
    imem_gnt = g;
    resp = 1'b0;
    if (pend.size() > 0) resp = pend[0].due <= cyc;
    imem_rvalid = resp;
    if (resp) imem_rdata = mem_word(pend[0].addr);
    else imem_rdata = $urandom;
    #1;
    last_req = imem_req;
    last_idv = id_valid;
    last_ins = id_instr;
    last_pcn = id_pc_next;
    if (imem_req) chk("issue_addr", imem_addr, exp_pc);
    if (rd) begin
      chk_b("req_in_redirect", imem_req, 1'b0);
      chk_b("idv_in_redirect", id_valid, 1'b0);
    end
    if (!id_valid) begin
      chk("nop_instr", id_instr, 32'h0);
      chk("nop_pc_next", id_pc_next, 32'h0);
    end
    popd = id_valid & !s & !rd;
    if (popd) begin
      chk("instr", id_instr, mem_word(exp_dpc));
      chk("pc_next", id_pc_next, exp_dpc + 32'd4);
    end
    iss = imem_req & g;
    @(posedge clock);
    if (resp) void'(pend.pop_front());
    if (iss) begin
      pend.push_back('{exp_pc, cyc + int'($urandom_range(lat_max, lat_min))});
      chk_b("inflight_bound", pend.size() <= DEPTH, 1'b1);
      issues++;
    end
    exp_pc = rd ? (rt & ~32'd3) : iss ? exp_pc + 32'd4 : exp_pc;
    exp_dpc = rd ? (rt & ~32'd3) : popd ? exp_dpc + 32'd4 : exp_dpc;
    if (popd) pops++;
    cyc++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[14];
    logic w_iss;
    tbl = '{
      '{O, Z, 32'h0,         Z, Z, 32'h0,  Z, 32'h0,  Z, 32'h0,         32'h0},
      '{O, Z, 32'h0,         Z, Z, 32'h0,  O, 32'h0,  Z, 32'h0,         32'h0},
      '{O, O, 32'hAAAA_0001, Z, Z, 32'h0,  O, 32'h4,  Z, 32'h0,         32'h0},
      '{O, O, 32'hBBBB_0002, Z, Z, 32'h0,  O, 32'h8,  O, 32'hAAAA_0001, 32'h4},
      '{Z, O, 32'hCCCC_0003, Z, Z, 32'h0,  O, 32'hC,  O, 32'hBBBB_0002, 32'h8},
      '{Z, Z, 32'h0,         Z, Z, 32'h0,  O, 32'hC,  O, 32'hCCCC_0003, 32'hC},
      '{Z, Z, 32'h0,         Z, Z, 32'h0,  O, 32'hC,  Z, 32'h0,         32'h0},
      '{O, Z, 32'h0,         Z, Z, 32'h0,  O, 32'hC,  Z, 32'h0,         32'h0},
      '{Z, O, 32'hDDDD_0004, Z, Z, 32'h0,  O, 32'h10, Z, 32'h0,         32'h0},
      '{O, Z, 32'h0,         O, Z, 32'h0,  O, 32'h10, O, 32'hDDDD_0004, 32'h10},
      '{O, O, 32'hEEEE_0005, O, O, 32'h43, Z, 32'h14, Z, 32'h0,         32'h0},
      '{Z, Z, 32'h0,         O, Z, 32'h0,  O, 32'h40, Z, 32'h0,         32'h0},
      '{Z, O, 32'hFFFF_0006, Z, Z, 32'h0,  O, 32'h40, Z, 32'h0,         32'h0},
      '{Z, Z, 32'h0,         Z, Z, 32'h0,  O, 32'h40, Z, 32'h0,         32'h0}
    };
    stall = 0; redirect_valid = 0; redirect_pc = 0; imem_gnt = 0;
    imem_rvalid = 0; imem_rdata = 0; w_gnt = 1; w_rvalid = 0; w_rdata = 0;
    repeat (3) @(negedge clock);
    chk_b("rst_req", imem_req, 1'b0);
    chk_b("rst_idv", id_valid, 1'b0);
    chk("rst_instr", id_instr, 32'h0);
    chk("rst_pc_next", id_pc_next, 32'h0);
    reset = 0;
    w_iss = 1'b0;
    for (int r = 0; r < 14; r++) begin
      if (r > 0) @(negedge clock);
      imem_gnt = tbl[r].g; imem_rvalid = tbl[r].rv; imem_rdata = tbl[r].rd;
      stall = tbl[r].st; redirect_valid = tbl[r].rdv; redirect_pc = tbl[r].rpc;
      w_rvalid = w_iss;
      w_rdata = 32'hC0DE_0000 + r;
      #1;
      chk_b($sformatf("vec%0d_req", r), imem_req, tbl[r].req);
      chk($sformatf("vec%0d_addr", r), imem_addr, tbl[r].addr);
      chk_b($sformatf("vec%0d_idv", r), id_valid, tbl[r].idv);
      chk($sformatf("vec%0d_instr", r), id_instr, tbl[r].ins);
      chk($sformatf("vec%0d_pc_next", r), id_pc_next, tbl[r].pcn);
      if (r == 0) chk_b("wrap_req_gated", w_req, 1'b0);
      if (r == 1) chk("wrap_addr0", w_addr, 32'hFFFF_FFFC);
      if (r == 2) chk("wrap_addr1", w_addr, 32'h0);
      if (r == 3) begin
        chk_b("wrap_idv", w_idv, 1'b1);
        chk("wrap_pc_next", w_pcn, 32'h0);
      end
      w_iss = w_req & w_gnt;
    end
    w_gnt = 0;
    w_rvalid = 0;
    exp_pc = 32'h40;
    exp_dpc = 32'h40;
    // stall held: request must drop once queue plus in-flight reach the depth
    issues = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b0, 32'h0, 1'b1);
      if (i >= 4) chk_b("stall_req_low", last_req, 1'b0);
    end
    chk("stall_issues", 32'(issues), 32'd4);
    pops = 0;
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 32'h0, 1'b1);
    chk_b("stall_release_pops", pops >= 4, 1'b1);
    step(1'b0, 1'b1, 32'h100, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
    // latency 3 with two requests in flight, then redirect to 0x40
    lat_min = 3; lat_max = 3;
    step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b1, 32'h40, 1'b1);
    last_idv = 1'b0;
    for (int i = 0; i < 20 && !last_idv; i++) step(1'b0, 1'b0, 32'h0, 1'b1);
    chk_b("redir_first_valid", last_idv, 1'b1);
    chk("redir_first_instr", last_ins, mem_word(32'h40));
    chk("redir_first_pc_next", last_pcn, 32'h44);
    // randomized traffic: stalls, grant gaps, variable latency, redirects
    lat_min = 1; lat_max = 4; pops = 0;
    for (int i = 0; i < 400; i++)
      step($urandom_range(9, 0) < 3, $urandom_range(19, 0) == 0, $urandom & 32'hFFFF, $urandom_range(9, 0) < 7);
    chk_b("random_progress", pops > 60, 1'b1);
    // asynchronous reset with a loaded queue and requests in flight
    step(1'b0, 1'b1, 32'h200, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
    lat_min = 3; lat_max = 3;
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'h0, 1'b1);
    chk_b("pre_reset_loaded", last_idv, 1'b1);
    #2;
    reset = 1;
    #1;
    chk_b("async_rst_req", imem_req, 1'b0);
    chk_b("async_rst_idv", id_valid, 1'b0);
    chk("async_rst_instr", id_instr, 32'h0);
    chk("async_rst_pc_next", id_pc_next, 32'h0);
    imem_gnt = 0; stall = 0; imem_rvalid = 1; imem_rdata = 32'h1234_5678;
    repeat (2) @(negedge clock);
    reset = 0;
    #1;
    chk_b("post_rst_req_gated", imem_req, 1'b0);
    chk_b("post_rst_idv0", id_valid, 1'b0);
    @(negedge clock);
    #1;
    chk_b("post_rst_req", imem_req, 1'b1);
    chk("post_rst_addr", imem_addr, 32'h0);
    chk_b("post_rst_idv1", id_valid, 1'b0);
    @(negedge clock);
    imem_rvalid = 0;
    #1;
    chk_b("late_rvalid_ignored", id_valid, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
